// File: rtl/dummy_stream_capture_slave_pkg.sv
// Shared types and helpers for the dummy AXI-Stream capture sink.
package dummy_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_FULL
  } state_t;

  localparam int unsigned PKT_CNT_W = 16;

  function automatic int unsigned depth(input int unsigned idx_w);
    return 32'd1 << idx_w;
  endfunction

endpackage

// File: rtl/dummy_stream_capture_slave_if.sv
// AXI-Stream handshake bundle feeding the capture sink.
interface dummy_stream_capture_slave_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] S_AXI_TDATA;
  logic                  S_AXI_TVALID;
  logic                  S_AXI_TREADY;
  logic                  S_AXI_TLAST;

  modport master (
    output S_AXI_TDATA,
    output S_AXI_TVALID,
    output S_AXI_TLAST,
    input  S_AXI_TREADY
  );

  modport slave (
    input  S_AXI_TDATA,
    input  S_AXI_TVALID,
    input  S_AXI_TLAST,
    output S_AXI_TREADY
  );
endinterface

// File: rtl/dummy_stream_capture_slave_mem.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module dummy_stream_mem
  import dummy_stream_pkg::*;
#(
  parameter int unsigned WIDTH  = 33,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  localparam int unsigned DEPTH = depth(ADDR_W);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read-during-write to the same address returns the previous contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/dummy_stream_capture_slave.sv
// AXI-Stream sink that records every accepted beat for later readback.
module dummy_stream_capture_slave
  import dummy_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned STORAGE_IDX_WIDTH = 10,
  parameter int unsigned SINK_MODE         = 0,
  parameter int unsigned THROTTLE_PERIOD   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  dummy_stream_capture_slave_if.slave  s_axi,
  input  logic                         clear,
  input  logic [STORAGE_IDX_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_last,
  output logic [STORAGE_IDX_WIDTH:0]   beat_cnt,
  output logic [PKT_CNT_W-1:0]         pkt_cnt,
  output logic                         full,
  output logic                         overflow,
  output logic                         in_packet
);
  localparam logic [STORAGE_IDX_WIDTH:0] DEPTH_V = {1'b1, {STORAGE_IDX_WIDTH{1'b0}}};
  localparam bit          RING  = (SINK_MODE != 0);
  localparam int unsigned THR_W = (THROTTLE_PERIOD >= 2) ? $clog2(THROTTLE_PERIOD) : 1;

  logic                         stall;
  logic                         tready;
  logic                         hs;
  logic                         fill_last;
  logic [STORAGE_IDX_WIDTH-1:0] wr_ptr;
  logic [DATA_WIDTH:0]          rd_word;
  state_t                       state, state_nxt;

  if (THROTTLE_PERIOD >= 2) begin : g_thr
    localparam logic [THR_W-1:0] THR_LAST = THR_W'(THROTTLE_PERIOD - 1);
    logic [THR_W-1:0] thr_cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                   thr_cnt <= '0;
      else if (thr_cnt == THR_LAST) thr_cnt <= '0;
      else                          thr_cnt <= thr_cnt + 1'b1;
    end

    assign stall = (thr_cnt == THR_LAST);
  end else begin : g_nothr
    assign stall = 1'b0;
  end

  assign full               = (beat_cnt == DEPTH_V);
  assign tready             = ~clear & ~stall & (RING | ~full) & reset;
  assign s_axi.S_AXI_TREADY = tready;
  assign hs                 = s_axi.S_AXI_TVALID & tready;
  assign fill_last          = hs & (beat_cnt == DEPTH_V - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      beat_cnt <= '0;
      pkt_cnt  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      beat_cnt <= '0;
      pkt_cnt  <= '0;
      overflow <= 1'b0;
    end else if (hs) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) beat_cnt <= beat_cnt + 1'b1;
      else       overflow <= 1'b1;
      if (s_axi.S_AXI_TLAST && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FULL is entered on the beat that fills the buffer, so the state never lags full.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else if (!RING && (full || fill_last)) begin
      state_nxt = S_FULL;
    end else begin
      unique case (state)
        S_IDLE:  if (hs && !s_axi.S_AXI_TLAST) state_nxt = S_RECV;
        S_RECV:  if (hs &&  s_axi.S_AXI_TLAST) state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  assign in_packet = (state == S_RECV);

  dummy_stream_mem #(
    .WIDTH  (DATA_WIDTH + 1),
    .ADDR_W (STORAGE_IDX_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (hs),
    .wr_addr (wr_ptr),
    .wr_data ({s_axi.S_AXI_TLAST, s_axi.S_AXI_TDATA}),
    .rd_addr (rd_addr),
    .rd_data (rd_word)
  );

  assign rd_data = rd_word[DATA_WIDTH-1:0];
  assign rd_last = rd_word[DATA_WIDTH];
endmodule

// File: tb/tb_dummy_stream_capture_slave.sv
// Directed bench for the capture sink: four configurations checked against a count-based model.
module tb_dummy_stream_capture_slave;

  localparam int NI = 4;

  function automatic int unsigned idx_of(input int i);
    return (i == 1 || i == 2) ? 2 : 10;
  endfunction
  function automatic int unsigned mode_of(input int i);
    return (i == 2) ? 1 : 0;
  endfunction
  function automatic int unsigned thr_of(input int i);
    return (i == 3) ? 4 : 0;
  endfunction
  function automatic int unsigned depth_of(input int i);
    return 32'd1 << idx_of(i);
  endfunction

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        tvalid [NI];
  logic        tlast  [NI];
  logic [31:0] tdata  [NI];
  logic        clr    [NI];
  logic [9:0]  rd_addr[NI];

  logic        tready [NI];
  logic [31:0] rdd    [NI];
  logic        rdl    [NI];
  logic [10:0] bcnt   [NI];
  logic [15:0] pcnt   [NI];
  logic        fullv  [NI];
  logic        ovfv   [NI];
  logic        inpk   [NI];

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int unsigned IW = idx_of(g);
    dummy_stream_capture_slave_if #(.DATA_WIDTH(32)) sif ();
    logic [IW:0] bc;

    assign sif.S_AXI_TVALID = tvalid[g];
    assign sif.S_AXI_TLAST  = tlast[g];
    assign sif.S_AXI_TDATA  = tdata[g];
    assign tready[g]        = sif.S_AXI_TREADY;
    assign bcnt[g]          = 11'(bc);

    dummy_stream_capture_slave #(
      .DATA_WIDTH        (32),
      .STORAGE_IDX_WIDTH (IW),
      .SINK_MODE         (mode_of(g)),
      .THROTTLE_PERIOD   (thr_of(g))
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .s_axi     (sif.slave),
      .clear     (clr[g]),
      .rd_addr   (rd_addr[g][IW-1:0]),
      .rd_data   (rdd[g]),
      .rd_last   (rdl[g]),
      .beat_cnt  (bc),
      .pkt_cnt   (pcnt[g]),
      .full      (fullv[g]),
      .overflow  (ovfv[g]),
      .in_packet (inpk[g])
    );
  end

  // Behavioural model: beats accepted since clear, packets seen, open-packet flag.
  int unsigned cyc;
  int unsigned stored[NI];
  int unsigned pkts  [NI];
  bit          mid   [NI];
  bit          ovf   [NI];
  logic [32:0] mdata [NI][1024];
  bit          mval  [NI][1024];
  logic [32:0] exp_rd   [NI];
  bit          exp_rd_ok[NI];

  int checks   = 0;
  int failures = 0;
  int hs3      = 0;
  logic rdy3_log[16];

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready(input int i);
    int unsigned tp = thr_of(i);
    logic stall_m = (tp >= 2) && ((cyc % tp) == tp - 1);
    return reset && !clr[i] && !stall_m && (mode_of(i) == 1 || stored[i] < depth_of(i));
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < NI; i++) begin
      stored[i] = 0; pkts[i] = 0; mid[i] = 0; ovf[i] = 0;
      exp_rd[i] = '0; exp_rd_ok[i] = 1;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      int unsigned d = depth_of(i);
      int unsigned ra = rd_addr[i] % d;
      int unsigned wa = stored[i] % d;
      exp_rd_ok[i] = mval[i][ra];
      exp_rd[i]    = mdata[i][ra];
      if (clr[i]) begin
        stored[i] = 0; pkts[i] = 0; mid[i] = 0; ovf[i] = 0;
      end else if (tvalid[i] && exp_ready(i)) begin
        if (stored[i] >= d) ovf[i] = 1;
        mdata[i][wa] = {tlast[i], tdata[i]};
        mval[i][wa]  = 1;
        stored[i]++;
        if (tlast[i]) pkts[i]++;
        mid[i] = !tlast[i];
      end
    end
    cyc++;
  endtask

  task automatic compare();
    for (int i = 0; i < NI; i++) begin
      int unsigned d = depth_of(i);
      chk("tready",    i, 32'(tready[i]), 32'(exp_ready(i)));
      chk("beat_cnt",  i, 32'(bcnt[i]),   (stored[i] < d) ? stored[i] : d);
      chk("pkt_cnt",   i, 32'(pcnt[i]),   (pkts[i] > 65535) ? 65535 : pkts[i]);
      chk("full",      i, 32'(fullv[i]),  32'(stored[i] >= d));
      chk("overflow",  i, 32'(ovfv[i]),   32'(ovf[i]));
      chk("in_packet", i, 32'(inpk[i]),   32'(mid[i] && !(mode_of(i) == 0 && stored[i] >= d)));
      if (exp_rd_ok[i]) begin
        chk("rd_data", i, rdd[i],        exp_rd[i][31:0]);
        chk("rd_last", i, 32'(rdl[i]),   32'(exp_rd[i][32]));
      end
    end
  endtask

  // One clock: log throttle instance, advance model, compare on the falling edge.
  task automatic step();
    #1;
    if (cyc < 16) begin
      rdy3_log[cyc] = tready[3];
      if (tvalid[3] && tready[3]) hs3++;
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    if (cyc >= 16) tvalid[3] = 1'b0;
    else           tdata[3]  = 32'hA0 + cyc;
  endtask

  task automatic send(input int i, input logic [31:0] d, input logic l);
    tvalid[i] = 1'b1; tdata[i] = d; tlast[i] = l;
    step();
    tvalid[i] = 1'b0; tlast[i] = 1'b0;
  endtask

  initial begin
    logic [31:0] t4_exp[4];
    int acc;
    logic rdy1_log[6];
    t4_exp = '{32'd5, 32'd6, 32'd3, 32'd4};

    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      tvalid[i] = 0; tlast[i] = 0; tdata[i] = '0; clr[i] = 0; rd_addr[i] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tvalid[3] = 1'b1; tdata[3] = 32'hA0;
    #1;
    compare();
    chk("t1_tready",   0, 32'(tready[0]), 1);
    chk("t1_beat_cnt", 0, 32'(bcnt[0]),   0);
    chk("t1_pkt_cnt",  0, 32'(pcnt[0]),   0);
    chk("t1_in_pkt",   0, 32'(inpk[0]),   0);
    chk("t1_overflow", 0, 32'(ovfv[0]),   0);

    // 3-beat packet into the default instance, then read back
    send(0, 32'h10, 1'b0);
    chk("t2_inpkt_b1", 0, 32'(inpk[0]), 1);
    send(0, 32'h11, 1'b0);
    send(0, 32'h12, 1'b1);
    chk("t2_inpkt_b3", 0, 32'(inpk[0]), 0);
    chk("t2_pkt_cnt",  0, 32'(pcnt[0]), 1);
    for (int a = 0; a < 3; a++) begin
      rd_addr[0] = 10'(a);
      step();
      chk("t2_rd_data", a, rdd[0],      32'h10 + 32'(a));
      chk("t2_rd_last", a, 32'(rdl[0]), (a == 2) ? 1 : 0);
    end

    // capture-until-full, depth 4
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      tvalid[1] = 1'b1; tdata[1] = 32'(k + 1);
      #1;
      rdy1_log[k] = tready[1];
      if (tready[1]) acc++;
      step();
    end
    tvalid[1] = 1'b0;
    chk("t3_accepted", 1, 32'(acc),         4);
    chk("t3_rdy_c3",   1, 32'(rdy1_log[3]), 1);
    chk("t3_rdy_c4",   1, 32'(rdy1_log[4]), 0);
    chk("t3_full",     1, 32'(fullv[1]),    1);
    chk("t3_beat_cnt", 1, 32'(bcnt[1]),     4);
    chk("t3_in_pkt",   1, 32'(inpk[1]),     0);
    clr[1] = 1'b1;
    #1;
    chk("t3_rdy_clr",  1, 32'(tready[1]), 0);
    step();
    clr[1] = 1'b0;
    #1;
    chk("t3_rdy_after", 1, 32'(tready[1]), 1);
    chk("t3_cnt_after", 1, 32'(bcnt[1]),   0);

    // ring overwrite, depth 4
    acc = 0;
    for (int k = 1; k <= 6; k++) begin
      tvalid[2] = 1'b1; tdata[2] = 32'(k);
      #1;
      if (tready[2]) acc++;
      step();
      if (k == 4) chk("t4_ovf_b4", 2, 32'(ovfv[2]), 0);
      if (k == 5) chk("t4_ovf_b5", 2, 32'(ovfv[2]), 1);
    end
    tvalid[2] = 1'b0;
    chk("t4_accepted", 2, 32'(acc),     6);
    chk("t4_beat_cnt", 2, 32'(bcnt[2]), 4);
    for (int a = 0; a < 4; a++) begin
      rd_addr[2] = 10'(a);
      step();
      chk("t4_mem", a, rdd[2], t4_exp[a]);
    end

    // throttle instance had TVALID high for the first 16 cycles after reset
    chk("t5_hs_count", 3, 32'(hs3), 12);
    for (int k = 0; k < 16; k++)
      chk("t5_rdy", k, 32'(rdy3_log[k]), (k % 4 == 3) ? 0 : 1);

    // reset in the middle of a packet
    send(0, 32'h20, 1'b0);
    send(0, 32'h21, 1'b0);
    chk("t6_mid_inpkt", 0, 32'(inpk[0]), 1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("t6_beat_cnt", 0, 32'(bcnt[0]),   0);
    chk("t6_pkt_cnt",  0, 32'(pcnt[0]),   0);
    chk("t6_in_pkt",   0, 32'(inpk[0]),   0);
    chk("t6_tready",   0, 32'(tready[0]), 0);
    chk("t6_rd_data",  0, rdd[0],         0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    compare();
    send(0, 32'h30, 1'b0);
    send(0, 32'h31, 1'b0);
    send(0, 32'h32, 1'b1);
    chk("t6_pkt_after",  0, 32'(pcnt[0]), 1);
    chk("t6_inpkt_after", 0, 32'(inpk[0]), 0);
    chk("t6_beats_after", 0, 32'(bcnt[0]), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
